// File: rtl/ifft_symbol_packer.sv
// ---------------------------------------------------------------------------
// ifft_symbol_packer
//
// Packs a stream of complex samples into one wide symbol for a downstream
// IFFT. Each input beat is one complex sample {real, imag}. Eight beats make
// one output symbol. Sample k of a symbol occupies bits [64k+63:64k], so the
// first accepted sample sits in the lowest lane.
//
// A symbol is closed by tlast or by the eighth beat, whichever comes first.
// If the two do not coincide, the symbol is still emitted. It is zero padded
// when short, and it is flagged on m_axis_tuser. The framing error is also
// latched into err_sticky.
//
// Ports
//   s_axis_aclk     in   single clock, rising edge
//   s_axis_aresetn  in   asynchronous active-low reset
//   s_axis_tvalid   in   input sample valid
//   s_axis_tready   out  input sample accepted when high with tvalid
//   s_axis_tdata    in   complex sample, real [63:32], imag [31:0]
//   s_axis_tlast    in   last sample of a symbol
//   m_axis_tvalid   out  packed symbol valid
//   m_axis_tready   in   downstream accepts the symbol
//   m_axis_tdata    out  packed symbol, lane 0 = first sample
//   m_axis_tuser    out  framing error flag for the presented symbol
//   err_sticky      out  any framing error since reset
// ---------------------------------------------------------------------------
module ifft_symbol_packer #(
  parameter int C_AXIS_TIN_WIDTH   = 64,
  parameter int C_AXIS_TDATA_WIDTH = 512
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_aresetn,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [C_AXIS_TIN_WIDTH-1:0]   s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tuser,
  output logic                          err_sticky
);

  localparam int LANES = C_AXIS_TDATA_WIDTH / C_AXIS_TIN_WIDTH;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  logic [CNT_W-1:0]              cnt;
  logic [C_AXIS_TDATA_WIDTH-1:0] asm_buf;
  logic [C_AXIS_TDATA_WIDTH-1:0] symbol_next;
  logic                          at_last_lane;
  logic                          xfer;
  logic                          complete;
  logic                          frame_err;

  // The only time a beat cannot be taken is when it would complete a full
  // symbol while the previous symbol is still waiting downstream. Below the
  // last lane, beats are only buffered, so input keeps flowing while the
  // output drains. A short symbol that completes during such a stall replaces
  // the waiting one. That symbol was already a framing error, so the error is
  // reported through err_sticky either way.
  assign at_last_lane  = (cnt == LAST_LANE);
  assign s_axis_tready = !(at_last_lane && m_axis_tvalid && !m_axis_tready);
  assign xfer          = s_axis_tvalid && s_axis_tready;
  assign complete      = xfer && (at_last_lane || s_axis_tlast);
  assign frame_err     = complete && !(at_last_lane && s_axis_tlast);

  // Build the outgoing symbol from the lanes gathered so far plus the beat
  // being accepted now. This lets a symbol load the output register on the
  // same edge as its final beat. Lanes above the current beat are cleared.
  // Without that, stale data from an earlier symbol would leak into a short
  // symbol.
  always_comb begin
    symbol_next = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k < int'(cnt)) begin
        symbol_next[k*C_AXIS_TIN_WIDTH +: C_AXIS_TIN_WIDTH] =
          asm_buf[k*C_AXIS_TIN_WIDTH +: C_AXIS_TIN_WIDTH];
      end else if (k == int'(cnt)) begin
        symbol_next[k*C_AXIS_TIN_WIDTH +: C_AXIS_TIN_WIDTH] = s_axis_tdata;
      end
    end
  end

  // Beat counter and assembly buffer. Each accepted beat lands in the lane
  // named by the counter. The counter wraps to zero on completion, so the beat
  // after a short or long symbol starts cleanly in lane 0. Idle cycles leave
  // everything untouched.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      cnt     <= '0;
      asm_buf <= '0;
    end else if (xfer) begin
      for (int k = 0; k < LANES; k++) begin
        if (k == int'(cnt)) begin
          asm_buf[k*C_AXIS_TIN_WIDTH +: C_AXIS_TIN_WIDTH] <= s_axis_tdata;
        end
      end
      cnt <= complete ? '0 : cnt + CNT_W'(1);
    end
  end

  // Output register. A completing symbol always wins, even when the old
  // symbol is handed off on the same edge. In that case valid simply stays
  // high with the new contents, and no symbol is dropped or repeated. With
  // no completion, a handshake empties the register. Otherwise data and user
  // hold still while downstream stalls.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
    end else if (complete) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= symbol_next;
      m_axis_tuser  <= frame_err;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Sticky framing error flag. Only reset clears it, so software can find
  // out that a framing slip happened at some point even after the flagged
  // symbol has left.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      err_sticky <= 1'b0;
    end else if (frame_err) begin
      err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifft_symbol_packer.sv
// ---------------------------------------------------------------------------
// tb_ifft_symbol_packer
//
// Driver tasks push beats into the packer. A reference model records each
// completed symbol in a queue. A separate monitor compares every presented
// symbol against the head of that queue. It also checks tready, err_sticky
// and valid on every falling edge.
// ---------------------------------------------------------------------------
module tb_ifft_symbol_packer;

  localparam int W     = 64;
  localparam int D     = 512;
  localparam int LANES = 8;

  typedef struct packed {
    logic [D-1:0] data;
    logic         user;
  } sym_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_tvalid;
  logic         s_tready;
  logic [W-1:0] s_tdata;
  logic         s_tlast;
  logic         m_tvalid;
  logic         m_tready;
  logic [D-1:0] m_tdata;
  logic         m_tuser;
  logic         err;

  int   total = 0;
  int   bad   = 0;
  sym_t sb_q[$];
  logic [W-1:0] exp_lanes [LANES];
  int   exp_cnt   = 0;
  logic exp_err   = 1'b0;
  int   ready_mode = 0;

  ifft_symbol_packer #(
    .C_AXIS_TIN_WIDTH  (W),
    .C_AXIS_TDATA_WIDTH(D)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_aresetn(rst_n),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .err_sticky    (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [D-1:0] actual,
                             input logic [D-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference model: collect lanes and close the symbol on lane 7 or tlast.
  task automatic modelBeat(input logic [W-1:0] data, input logic last);
    sym_t s;
    exp_lanes[exp_cnt] = data;
    if (exp_cnt == LANES - 1 || last) begin
      s.data = '0;
      for (int k = 0; k <= exp_cnt; k++) s.data[k*W +: W] = exp_lanes[k];
      s.user = !(exp_cnt == LANES - 1 && last);
      if (s.user) exp_err = 1'b1;
      sb_q.push_back(s);
      exp_cnt = 0;
    end else begin
      exp_cnt++;
    end
  endtask

  // Drives one beat, starting just after a rising edge. Returns just after
  // the edge that accepted the beat.
  task automatic applyStimulus(input logic [W-1:0] data, input logic last,
                               input int gap);
    bit ok;
    bit accepted;
    int waited;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b1;
    s_tdata  = data;
    s_tlast  = last;
    accepted = 1'b0;
    waited   = 0;
    while (!accepted) begin
      @(negedge clk);
      ok = s_tready;
      @(posedge clk);
      if (ok) begin
        modelBeat(data, last);
        accepted = 1'b1;
      end
      #1;
      if (!accepted) begin
        waited++;
        if (waited > 200) begin
          total++;
          bad++;
          $display("[TB] FAIL beat_accept: got no tready expected accept within 200 cycles");
          break;
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic sendSymbol(input logic [W-1:0] base, input int nbeats,
                            input int last_at, input bit rnd);
    logic [W-1:0] d;
    for (int i = 0; i < nbeats; i++) begin
      d = rnd ? {$urandom(), $urandom()} : base + W'(i);
      applyStimulus(d, (i == last_at), rnd ? int'($urandom_range(0, 1)) : 0);
    end
  endtask

  task automatic setReadyMode(input int mode);
    @(negedge clk);
    ready_mode = mode;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    exp_cnt = 0;
    exp_err = 1'b0;
    checkOutput("rst_m_tvalid", D'(m_tvalid), D'(1'b0));
    checkOutput("rst_m_tuser",  D'(m_tuser),  D'(1'b0));
    checkOutput("rst_err",      D'(err),      D'(1'b0));
    checkOutput("rst_m_tdata",  m_tdata,      '0);
    checkOutput("rst_s_tready", D'(s_tready), D'(1'b1));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Downstream ready generator.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'b0;
        default: m_tready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Monitor: compares against the model on every falling edge out of reset.
  initial begin
    logic exp_rdy;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_rdy = !(exp_cnt == LANES - 1 && sb_q.size() > 0 && !m_tready);
        checkOutput("s_tready", D'(s_tready), D'(exp_rdy));
        checkOutput("err_sticky", D'(err), D'(exp_err));
        checkOutput("m_tvalid", D'(m_tvalid), D'(sb_q.size() > 0));
        if (m_tvalid && sb_q.size() > 0) begin
          checkOutput("m_tdata", m_tdata, sb_q[0].data);
          checkOutput("m_tuser", D'(m_tuser), D'(sb_q[0].user));
          if (m_tready) begin
            @(posedge clk);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] re;
    logic [31:0] im;
    int          waited;
    rst_n    = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    #2;
    doReset();

    // Continuous well-framed symbol, lane k = {k+1, -(k+1)}
    for (int k = 0; k < LANES; k++) begin
      re = 32'(k + 1);
      im = -re;
      applyStimulus({re, im}, (k == LANES - 1), 0);
    end
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back symbols with downstream stalled for 10 cycles
    setReadyMode(1);
    sendSymbol(64'h0A0A_0000_0000_0100, 8, 7, 1'b0);
    fork
      sendSymbol(64'h0B0B_0000_0000_0200, 8, 7, 1'b0);
      begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        ready_mode = 0;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Short symbol: tlast on beat 2, real fields 0xA, 0xB, 0xC
    applyStimulus(64'h0000000A_00000000, 1'b0, 0);
    applyStimulus(64'h0000000B_00000000, 1'b0, 0);
    applyStimulus(64'h0000000C_00000000, 1'b1, 0);
    repeat (3) @(posedge clk);
    #1;

    // Long symbol with no tlast, then a well-framed one
    sendSymbol(64'h1111_0000_0000_0000, 8, -1, 1'b0);
    sendSymbol(64'h2222_0000_0000_0000, 8, 7, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Reset with a pending symbol and four partial beats, then fresh data
    setReadyMode(1);
    sendSymbol(64'h3333_0000_0000_0000, 8, 7, 1'b0);
    sendSymbol(64'h4444_0000_0000_0000, 4, -1, 1'b0);
    doReset();
    ready_mode = 0;
    @(posedge clk);
    #1;
    sendSymbol(64'h5555_0000_0000_0000, 8, 7, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Random valid gaps and random downstream ready
    setReadyMode(2);
    for (int s = 0; s < 1000; s++) sendSymbol('0, 8, 7, 1'b1);
    setReadyMode(0);

    waited = 0;
    while (sb_q.size() > 0 && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput("drain", D'(sb_q.size()), D'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
